stopwatch_counter: RTL

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_counter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// MM:SS stopwatch with run/pause and a manual adjust mode. The count is held
// as four BCD digits. It drives four registered active-low 7-segment patterns.
//
// Parameters
//   MIN_MAX      highest minutes value before the minutes wrap to 00 (1..99)
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   tick_1hz     1-clk enable pulse, advances the count in RUN
//   tick_2hz     1-clk enable pulse, advances the selected field in ADJUST
//   adj          level, 1 = adjust mode
//   sel          adjust field select: 0 = minutes, 1 = seconds
//   pause        debounced pause button level; a rising edge toggles pause
//   seg_min_top  7-seg pattern, minutes tens   (bit7 = dp, bits6:0 = gfedcba)
//   seg_min_bot  7-seg pattern, minutes ones
//   seg_sec_top  7-seg pattern, seconds tens
//   seg_sec_bot  7-seg pattern, seconds ones
//   paused       1 while the paused flag is set
// -----------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause,
    output logic [7:0] seg_min_top,
    output logic [7:0] seg_min_bot,
    output logic [7:0] seg_sec_top,
    output logic [7:0] seg_sec_bot,
    output logic       paused
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_ADJUST
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
    localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);
    localparam logic [7:0] SEG_ZERO = 8'hC0;

    // Count digits
    logic [3:0] min_t_q, min_t_d;
    logic [3:0] min_o_q, min_o_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] sec_o_q, sec_o_d;

    // Pause handling
    logic paused_q, paused_d;
    logic pause_q,  pause_d;
    logic armed_q,  armed_d;

    // Registered segment outputs
    logic [7:0] seg_min_top_q, seg_min_top_d;
    logic [7:0] seg_min_bot_q, seg_min_bot_d;
    logic [7:0] seg_sec_top_q, seg_sec_top_d;
    logic [7:0] seg_sec_bot_q, seg_sec_bot_d;

    state_t state;

    logic sec_at_max;
    logic min_at_max;
    logic inc_sec;
    logic inc_min;
    logic toggle_req;

    // BCD digit to active-low segment pattern; dp always off, non-BCD blanks.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = 8'hC0;
            4'd1:    pattern = 8'hF9;
            4'd2:    pattern = 8'hA4;
            4'd3:    pattern = 8'hB0;
            4'd4:    pattern = 8'h99;
            4'd5:    pattern = 8'h92;
            4'd6:    pattern = 8'h82;
            4'd7:    pattern = 8'hF8;
            4'd8:    pattern = 8'h80;
            4'd9:    pattern = 8'h90;
            default: pattern = 8'hFF;
        endcase
        return pattern;
    endfunction

    // The mode is fully determined by adj and the paused flag, so the flag
    // register is the only stored state; decoding it combinationally lets adj
    // take effect in the same cycle it changes.
    always_comb begin
        state = ST_RUN;
        if (adj) begin
            state = ST_ADJUST;
        end else if (paused_q) begin
            state = ST_PAUSED;
        end
    end

    always_comb begin
        min_t_d       = min_t_q;
        min_o_d       = min_o_q;
        sec_t_d       = sec_t_q;
        sec_o_d       = sec_o_q;
        paused_d      = paused_q;
        pause_d       = pause;
        armed_d       = armed_q | ~pause;
        inc_sec       = 1'b0;
        inc_min       = 1'b0;

        sec_at_max = (sec_t_q == 4'd5) && (sec_o_q == 4'd9);
        min_at_max = (min_t_q == MAX_T) && (min_o_q == MAX_O);

        // armed_q blocks a "rising edge" that is really a level held through reset.
        toggle_req = pause & ~pause_q & armed_q;

        unique case (state)
            ST_RUN: begin
                if (tick_1hz) begin
                    inc_sec = 1'b1;
                    inc_min = sec_at_max;
                end
                if (toggle_req) begin
                    paused_d = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (toggle_req) begin
                    paused_d = 1'b0;
                end
            end
            ST_ADJUST: begin
                if (tick_2hz) begin
                    if (sel) begin
                        inc_sec = 1'b1;
                    end else begin
                        inc_min = 1'b1;
                    end
                end
            end
            default: begin
                paused_d = paused_q;
            end
        endcase

        if (inc_sec) begin
            if (sec_at_max) begin
                sec_t_d = '0;
                sec_o_d = '0;
            end else if (sec_o_q == 4'd9) begin
                sec_t_d = sec_t_q + 4'd1;
                sec_o_d = '0;
            end else begin
                sec_o_d = sec_o_q + 4'd1;
            end
        end

        if (inc_min) begin
            if (min_at_max) begin
                min_t_d = '0;
                min_o_d = '0;
            end else if (min_o_q == 4'd9) begin
                min_t_d = min_t_q + 4'd1;
                min_o_d = '0;
            end else begin
                min_o_d = min_o_q + 4'd1;
            end
        end

        // Segments follow the stored count, giving one cycle of latency.
        seg_min_top_d = seg_encode(min_t_q);
        seg_min_bot_d = seg_encode(min_o_q);
        seg_sec_top_d = seg_encode(sec_t_q);
        seg_sec_bot_d = seg_encode(sec_o_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_t_q       <= '0;
            min_o_q       <= '0;
            sec_t_q       <= '0;
            sec_o_q       <= '0;
            paused_q      <= 1'b0;
            pause_q       <= 1'b0;
            // A pause level still high as reset releases must not count as an edge.
            armed_q       <= ~pause;
            seg_min_top_q <= SEG_ZERO;
            seg_min_bot_q <= SEG_ZERO;
            seg_sec_top_q <= SEG_ZERO;
            seg_sec_bot_q <= SEG_ZERO;
        end else begin
            min_t_q       <= min_t_d;
            min_o_q       <= min_o_d;
            sec_t_q       <= sec_t_d;
            sec_o_q       <= sec_o_d;
            paused_q      <= paused_d;
            pause_q       <= pause_d;
            armed_q       <= armed_d;
            seg_min_top_q <= seg_min_top_d;
            seg_min_bot_q <= seg_min_bot_d;
            seg_sec_top_q <= seg_sec_top_d;
            seg_sec_bot_q <= seg_sec_bot_d;
        end
    end

    assign seg_min_top = seg_min_top_q;
    assign seg_min_bot = seg_min_bot_q;
    assign seg_sec_top = seg_sec_top_q;
    assign seg_sec_bot = seg_sec_bot_q;
    assign paused      = paused_q;

endmodule
